// File: rtl/k423_id_regfile_sb_pkg.sv
// Shared widths and operand-size type for the ID-stage register file and scoreboard.
`include "k423_defines.svh"

package k423_id_regfile_sb_pkg;

  localparam int unsigned IDX_W  = `INST_RSDIDX_W;
  localparam int unsigned SIZE_W = `RSD_SIZE_W;
  localparam int unsigned NREG   = `RF_NREG;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [SIZE_W-1:0] {
    SZ_BYTE = `RSD_SIZE_BYTE,
    SZ_HALF = `RSD_SIZE_HALF,
    SZ_WORD = `RSD_SIZE_WORD
  } rsd_size_e;

endpackage

// File: rtl/k423_defines.svh
// Core-wide widths and operand-size encodings shared by the ID-stage blocks.
`ifndef K423_DEFINES_SVH
`define K423_DEFINES_SVH

`define CORE_XLEN      32
`define INST_RSDIDX_W  5
`define RSD_SIZE_W     2
`define RSD_SIZE_BYTE  2'd0
`define RSD_SIZE_HALF  2'd1
`define RSD_SIZE_WORD  2'd2
`define RF_NREG        32

`endif

// File: rtl/k423_id_regfile_sb_scoreboard.sv
// Per-register pending-write counters: issue increments, retire decrements, flush clears.
module k423_id_scoreboard
  import k423_id_regfile_sb_pkg::*;
#(
  parameter int unsigned NUM_WR = 1,
  parameter int unsigned PEND_W = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         issue_fire,
  input  logic                         issue_wen,
  input  logic [IDX_W-1:0]             issue_idx,
  input  logic [NUM_WR-1:0]            wr_vld,
  input  logic [NUM_WR-1:0][IDX_W-1:0] wr_idx,
  output logic [NREG-1:0]              busy,
  output logic                         issue_sat_c
);

  logic [PEND_W-1:0] pend_q [NREG];
  logic [NREG-1:0]   inc_c;
  logic [NREG-1:0]   dec_c;

  // Retire mask; duplicate retires of one register collapse to a single decrement.
  always_comb begin
    dec_c = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_vld[w] && wr_idx[w] != '0) dec_c[wr_idx[w]] = 1'b1;
    end
  end

  always_comb begin
    inc_c = '0;
    if (issue_fire && issue_wen && issue_idx != '0) inc_c[issue_idx] = 1'b1;
  end

  // A full counter blocks issue unless the same register retires this cycle.
  always_comb begin
    issue_sat_c = issue_wen && (issue_idx != '0) && (&pend_q[issue_idx]) && !dec_c[issue_idx];
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++) busy[r] = (pend_q[r] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_c[r] && !dec_c[r]) begin
          pend_q[r] <= pend_q[r] + PEND_W'(1);
        end else if (dec_c[r] && !inc_c[r] && pend_q[r] != '0) begin
          pend_q[r] <= pend_q[r] - PEND_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/k423_id_regfile_sb.sv
// ID-stage register file with forwarding network, write-first bypass and pending-write stall.
`include "k423_defines.svh"

module k423_id_regfile_sb
  import k423_id_regfile_sb_pkg::*;
#(
  parameter int unsigned NUM_RD  = 2,
  parameter int unsigned NUM_WR  = 1,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned XLEN    = `CORE_XLEN,
  parameter int unsigned PEND_W  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          flush_i,
  input  logic [NUM_FWD-1:0]            fwd_vld_i,
  input  logic [NUM_FWD-1:0]            fwd_data_vld_i,
  input  logic [NUM_FWD-1:0][IDX_W-1:0] fwd_idx_i,
  input  logic [NUM_FWD-1:0][XLEN-1:0]  fwd_data_i,
  input  logic [NUM_WR-1:0]             wr_vld_i,
  input  logic [NUM_WR-1:0][IDX_W-1:0]  wr_idx_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]   wr_data_i,
  input  logic [NUM_RD-1:0]             rd_vld_i,
  input  logic [NUM_RD-1:0][IDX_W-1:0]  rd_idx_i,
  input  logic [NUM_RD-1:0][SIZE_W-1:0] rd_size_i,
  output logic [NUM_RD-1:0][XLEN-1:0]   rd_data_o,
  input  logic                          issue_vld_i,
  input  logic                          issue_rd_wen_i,
  input  logic [IDX_W-1:0]              issue_rd_idx_i,
  output logic                          stall_o,
  output logic [CNT_W-1:0]              stall_cnt_o
);

  logic [XLEN-1:0]   regs_q [NREG];
  logic [NREG-1:0]   busy;
  logic              issue_sat_c;
  logic              issue_fire_c;
  logic [NUM_RD-1:0] rd_stall_c;

  // x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_vld_i[w] && wr_idx_i[w] != '0) regs_q[wr_idx_i[w]] <= wr_data_i[w];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic            fwd_hit_c;
    logic            fwd_rdy_c;
    logic [XLEN-1:0] fwd_sel_c;
    logic            wr_hit_c;
    logic [XLEN-1:0] wr_sel_c;
    logic [XLEN-1:0] sel_c;
    logic [XLEN-1:0] ext_c;
    logic            stall_c;

    // Youngest matching forward source wins; latest matching write port wins.
    always_comb begin
      fwd_hit_c = 1'b0;
      fwd_rdy_c = 1'b0;
      fwd_sel_c = '0;
      for (int s = 0; s < NUM_FWD; s++) begin
        if (!fwd_hit_c && fwd_vld_i[s] && fwd_idx_i[s] == rd_idx_i[p]) begin
          fwd_hit_c = 1'b1;
          fwd_rdy_c = fwd_data_vld_i[s];
          fwd_sel_c = fwd_data_i[s];
        end
      end
      wr_hit_c = 1'b0;
      wr_sel_c = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_vld_i[w] && wr_idx_i[w] == rd_idx_i[p]) begin
          wr_hit_c = 1'b1;
          wr_sel_c = wr_data_i[w];
        end
      end
    end

    always_comb begin
      sel_c   = '0;
      stall_c = 1'b0;
      if (rd_vld_i[p] && rd_idx_i[p] != '0) begin
        if (fwd_hit_c) begin
          if (fwd_rdy_c) sel_c = fwd_sel_c;
          else           stall_c = 1'b1;
        end else if (wr_hit_c) begin
          sel_c = wr_sel_c;
        end else if (busy[rd_idx_i[p]]) begin
          stall_c = 1'b1;
        end else begin
          sel_c = regs_q[rd_idx_i[p]];
        end
      end
    end

    always_comb begin
      ext_c = sel_c;
      case (rsd_size_e'(rd_size_i[p]))
        SZ_BYTE: ext_c = {{(XLEN-8){sel_c[7]}}, sel_c[7:0]};
        SZ_HALF: ext_c = {{(XLEN-16){sel_c[15]}}, sel_c[15:0]};
        default: ext_c = sel_c;
      endcase
    end

    assign rd_data_o[p]  = ext_c;
    assign rd_stall_c[p] = stall_c;
  end

  assign stall_o      = (|rd_stall_c) || issue_sat_c;
  assign issue_fire_c = issue_vld_i && !stall_o;

  k423_id_scoreboard #(
    .NUM_WR (NUM_WR),
    .PEND_W (PEND_W)
  ) u_sb (
    .clk         (clk_i),
    .rst_n       (rst_n_i),
    .flush       (flush_i),
    .issue_fire  (issue_fire_c),
    .issue_wen   (issue_rd_wen_i),
    .issue_idx   (issue_rd_idx_i),
    .wr_vld      (wr_vld_i),
    .wr_idx      (wr_idx_i),
    .busy        (busy),
    .issue_sat_c (issue_sat_c)
  );

  // Saturating count of cycles where a waiting instruction is held.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (issue_vld_i && stall_o && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_k423_id_regfile_sb.sv
// Self-checking bench for k423_id_regfile_sb: directed scenarios plus randomized traffic vs a reference model.
module tb_k423_id_regfile_sb;

  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int NFWD = 3;
  localparam logic [1:0] SB = 2'd0;
  localparam logic [1:0] SH = 2'd1;
  localparam logic [1:0] SW = 2'd2;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic flush_i;
  logic [NFWD-1:0]       fwd_vld_i, fwd_data_vld_i;
  logic [NFWD-1:0][4:0]  fwd_idx_i;
  logic [NFWD-1:0][31:0] fwd_data_i;
  logic [NWR-1:0]        wr_vld_i;
  logic [NWR-1:0][4:0]   wr_idx_i;
  logic [NWR-1:0][31:0]  wr_data_i;
  logic [NRD-1:0]        rd_vld_i;
  logic [NRD-1:0][4:0]   rd_idx_i;
  logic [NRD-1:0][1:0]   rd_size_i;
  logic [NRD-1:0][31:0]  rd_data_o;
  logic                  issue_vld_i, issue_rd_wen_i;
  logic [4:0]            issue_rd_idx_i;
  logic                  stall_o;
  logic [31:0]           stall_cnt_o;

  int chk = 0;
  int fails = 0;

  logic [31:0] m_regs [32];
  int          m_pend [32];
  logic [31:0] m_cnt;
  logic [31:0] exp_data [NRD];
  logic [NRD-1:0] exp_pst;
  logic        exp_stall;

  k423_id_regfile_sb #(.NUM_RD(NRD), .NUM_WR(NWR), .NUM_FWD(NFWD), .XLEN(32), .PEND_W(2)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .fwd_vld_i(fwd_vld_i), .fwd_data_vld_i(fwd_data_vld_i), .fwd_idx_i(fwd_idx_i), .fwd_data_i(fwd_data_i),
    .wr_vld_i(wr_vld_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i),
    .rd_vld_i(rd_vld_i), .rd_idx_i(rd_idx_i), .rd_size_i(rd_size_i), .rd_data_o(rd_data_o),
    .issue_vld_i(issue_vld_i), .issue_rd_wen_i(issue_rd_wen_i), .issue_rd_idx_i(issue_rd_idx_i),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_pend[r] = 0; end
    m_cnt = '0;
  endtask

  // Reference read/stall outcome computed from the architectural model state.
  task automatic model_eval();
    logic [31:0] v;
    int f, ws;
    bit ret;
    exp_stall = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      v = '0;
      exp_pst[p] = 1'b0;
      if (rd_vld_i[p] && rd_idx_i[p] != 5'd0) begin
        f = -1;
        for (int s = 0; s < NFWD; s++)
          if (f < 0 && fwd_vld_i[s] && fwd_idx_i[s] == rd_idx_i[p]) f = s;
        ws = -1;
        for (int w = 0; w < NWR; w++)
          if (wr_vld_i[w] && wr_idx_i[w] == rd_idx_i[p]) ws = w;
        if (f >= 0) begin
          if (fwd_data_vld_i[f]) v = fwd_data_i[f]; else exp_pst[p] = 1'b1;
        end else if (ws >= 0) v = wr_data_i[ws];
        else if (m_pend[rd_idx_i[p]] != 0) exp_pst[p] = 1'b1;
        else v = m_regs[rd_idx_i[p]];
        if (rd_size_i[p] == SB) v = 32'($signed(v[7:0]));
        else if (rd_size_i[p] == SH) v = 32'($signed(v[15:0]));
      end
      exp_data[p] = v;
      if (exp_pst[p]) exp_stall = 1'b1;
    end
    if (issue_rd_wen_i && issue_rd_idx_i != 5'd0 && m_pend[issue_rd_idx_i] == 3) begin
      ret = 1'b0;
      for (int w = 0; w < NWR; w++) if (wr_vld_i[w] && wr_idx_i[w] == issue_rd_idx_i) ret = 1'b1;
      if (!ret) exp_stall = 1'b1;
    end
  endtask

  task automatic model_commit();
    bit fire;
    bit [31:0] ret;
    int d;
    model_eval();
    fire = issue_vld_i && !exp_stall;
    if (issue_vld_i && exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    ret = '0;
    for (int w = 0; w < NWR; w++)
      if (wr_vld_i[w] && wr_idx_i[w] != 5'd0) begin m_regs[wr_idx_i[w]] = wr_data_i[w]; ret[wr_idx_i[w]] = 1'b1; end
    for (int r = 0; r < 32; r++) begin
      if (flush_i) m_pend[r] = 0;
      else begin
        d = 0;
        if (fire && issue_rd_wen_i && issue_rd_idx_i == 5'(r) && r != 0) d = d + 1;
        if (ret[r]) d = d - 1;
        m_pend[r] = m_pend[r] + d;
        if (m_pend[r] < 0) m_pend[r] = 0;
      end
    end
  endtask

  task automatic clear_in();
    flush_i = 0; fwd_vld_i = '0; fwd_data_vld_i = '0; fwd_idx_i = '0; fwd_data_i = '0;
    wr_vld_i = '0; wr_idx_i = '0; wr_data_i = '0; rd_vld_i = '0; rd_idx_i = '0; rd_size_i = '0;
    issue_vld_i = 0; issue_rd_wen_i = 0; issue_rd_idx_i = '0;
  endtask

  task automatic set_rd(input int p, input logic [4:0] idx, input logic [1:0] sz);
    rd_vld_i[p] = 1'b1; rd_idx_i[p] = idx; rd_size_i[p] = sz;
  endtask

  task automatic set_wr(input int w, input logic [4:0] idx, input logic [31:0] data);
    wr_vld_i[w] = 1'b1; wr_idx_i[w] = idx; wr_data_i[w] = data;
  endtask

  task automatic set_fwd(input int s, input logic [4:0] idx, input logic dv, input logic [31:0] data);
    fwd_vld_i[s] = 1'b1; fwd_idx_i[s] = idx; fwd_data_vld_i[s] = dv; fwd_data_i[s] = data;
  endtask

  task automatic set_issue(input logic [4:0] idx);
    issue_vld_i = 1'b1; issue_rd_wen_i = 1'b1; issue_rd_idx_i = idx;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk_i);
    #1;
    clear_in();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i += 2) begin
      clear_in(); set_rd(0, 5'(i), SW); set_rd(1, 5'(i + 1), SW); settle();
      chk++; if (rd_data_o[0] !== 32'h0 || rd_data_o[1] !== 32'h0 || stall_o !== 1'b0) begin
        fails++; $display("FAIL reset_read x%0d: got %h/%h stall %b, want 0/0 stall 0", i, rd_data_o[0], rd_data_o[1], stall_o);
      end
    end
    chk++; if (stall_cnt_o !== 32'h0) begin fails++; $display("FAIL reset_cnt: got %h want 0", stall_cnt_o); end
    clear_in();
  endtask

  task automatic test_size_ext();
    set_wr(0, 5'd5, 32'h80); set_wr(1, 5'd6, 32'h8001); tick();
    set_rd(0, 5'd5, SB); set_rd(1, 5'd5, SW); settle();
    chk++; if (rd_data_o[0] !== 32'hFFFF_FF80 || stall_o !== 1'b0) begin fails++; $display("FAIL byte_ext: got %h stall %b want ffffff80 stall 0", rd_data_o[0], stall_o); end
    chk++; if (rd_data_o[1] !== 32'h0000_0080) begin fails++; $display("FAIL word_pass: got %h want 00000080", rd_data_o[1]); end
    clear_in(); set_rd(0, 5'd6, SH); settle();
    chk++; if (rd_data_o[0] !== 32'hFFFF_8001) begin fails++; $display("FAIL half_ext: got %h want ffff8001", rd_data_o[0]); end
    clear_in(); set_wr(0, 5'd10, 32'hAAAA_0000); set_wr(1, 5'd10, 32'h5555_1234); set_rd(0, 5'd10, SW); settle();
    chk++; if (rd_data_o[0] !== 32'h5555_1234) begin fails++; $display("FAIL wr_conflict_bypass: got %h want 55551234", rd_data_o[0]); end
    tick(); set_rd(1, 5'd10, SW); settle();
    chk++; if (rd_data_o[1] !== 32'h5555_1234) begin fails++; $display("FAIL wr_conflict_rf: got %h want 55551234", rd_data_o[1]); end
    clear_in();
  endtask

  task automatic test_fwd();
    set_fwd(0, 5'd7, 1'b0, 32'h0); set_fwd(1, 5'd7, 1'b1, 32'h11); set_fwd(2, 5'd8, 1'b1, 32'h33);
    set_rd(0, 5'd7, SW); set_rd(1, 5'd8, SW); settle();
    chk++; if (stall_o !== 1'b1) begin fails++; $display("FAIL fwd_nodata_stall: got %b want 1", stall_o); end
    chk++; if (rd_data_o[1] !== 32'h33) begin fails++; $display("FAIL fwd2_data: got %h want 00000033", rd_data_o[1]); end
    set_fwd(0, 5'd7, 1'b1, 32'h22); settle();
    chk++; if (rd_data_o[0] !== 32'h22 || stall_o !== 1'b0) begin fails++; $display("FAIL fwd_prio: got %h stall %b want 00000022 stall 0", rd_data_o[0], stall_o); end
    rd_vld_i[0] = 1'b0; fwd_data_vld_i[0] = 1'b0; settle();
    chk++; if (stall_o !== 1'b0 || rd_data_o[0] !== 32'h0) begin fails++; $display("FAIL unused_port: got %h stall %b want 0 stall 0", rd_data_o[0], stall_o); end
    clear_in();
  endtask

  task automatic test_pending();
    set_issue(5'd3); settle();
    chk++; if (stall_o !== 1'b0) begin fails++; $display("FAIL issue_fire: got stall %b want 0", stall_o); end
    tick(); set_rd(0, 5'd3, SW); settle();
    chk++; if (stall_o !== 1'b1) begin fails++; $display("FAIL pend_stall: got %b want 1", stall_o); end
    set_wr(0, 5'd3, 32'h9); settle();
    chk++; if (rd_data_o[0] !== 32'h9 || stall_o !== 1'b0) begin fails++; $display("FAIL retire_bypass: got %h stall %b want 00000009 stall 0", rd_data_o[0], stall_o); end
    tick(); set_rd(0, 5'd3, SW); settle();
    chk++; if (rd_data_o[0] !== 32'h9 || stall_o !== 1'b0) begin fails++; $display("FAIL pend_cleared: got %h stall %b want 00000009 stall 0", rd_data_o[0], stall_o); end
    clear_in();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      set_issue(5'd4); settle();
      chk++; if (stall_o !== 1'b0) begin fails++; $display("FAIL sat_issue%0d: got stall %b want 0", i, stall_o); end
      tick();
    end
    set_issue(5'd4); settle();
    chk++; if (stall_o !== 1'b1) begin fails++; $display("FAIL sat_block: got %b want 1", stall_o); end
    tick();
    chk++; if (stall_cnt_o !== m_cnt || m_cnt !== 32'd1) begin fails++; $display("FAIL sat_cnt: got %h want 00000001", stall_cnt_o); end
    set_issue(5'd4); set_wr(0, 5'd4, 32'h44); settle();
    chk++; if (stall_o !== 1'b0) begin fails++; $display("FAIL sat_retire_fire: got %b want 0", stall_o); end
    tick(); set_issue(5'd4); settle();
    chk++; if (stall_o !== 1'b1) begin fails++; $display("FAIL sat_still_full: got %b want 1", stall_o); end
    clear_in();
    for (int i = 0; i < 3; i++) begin set_wr(1, 5'd4, 32'h44); tick(); end
    set_rd(1, 5'd4, SW); settle();
    chk++; if (rd_data_o[1] !== 32'h44 || stall_o !== 1'b0) begin fails++; $display("FAIL sat_drained: got %h stall %b want 00000044 stall 0", rd_data_o[1], stall_o); end
    clear_in();
  endtask

  task automatic test_x0();
    set_wr(0, 5'd0, 32'hFFFF); set_issue(5'd0); set_rd(0, 5'd0, SW); settle();
    chk++; if (rd_data_o[0] !== 32'h0 || stall_o !== 1'b0) begin fails++; $display("FAIL x0_same: got %h stall %b want 0 stall 0", rd_data_o[0], stall_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      set_issue(5'd0); set_rd(0, 5'd0, SB); settle();
      chk++; if (rd_data_o[0] !== 32'h0 || stall_o !== 1'b0) begin fails++; $display("FAIL x0_iter%0d: got %h stall %b want 0 stall 0", i, rd_data_o[0], stall_o); end
      tick();
    end
  endtask

  task automatic test_flush();
    set_wr(0, 5'd9, 32'h1234); tick();
    set_issue(5'd9); tick(); set_issue(5'd9); tick();
    set_rd(0, 5'd9, SW); flush_i = 1'b1; settle();
    chk++; if (stall_o !== 1'b1) begin fails++; $display("FAIL flush_cycle_stall: got %b want 1", stall_o); end
    tick(); set_rd(0, 5'd9, SW); settle();
    chk++; if (rd_data_o[0] !== 32'h1234 || stall_o !== 1'b0) begin fails++; $display("FAIL flush_clear: got %h stall %b want 00001234 stall 0", rd_data_o[0], stall_o); end
    clear_in();
  endtask

  task automatic test_random();
    logic [4:0] idx;
    for (int c = 0; c < 400; c++) begin
      clear_in();
      flush_i = ($urandom_range(0, 39) == 0);
      for (int s = 0; s < NFWD; s++) begin
        fwd_vld_i[s] = 1'($urandom_range(0, 1)); fwd_data_vld_i[s] = ($urandom_range(0, 2) != 0);
        fwd_idx_i[s] = 5'($urandom_range(0, 7)); fwd_data_i[s] = $urandom;
      end
      for (int w = 0; w < NWR; w++) begin
        idx = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1 && (idx == 5'd0 || m_pend[idx] > 0)) set_wr(w, idx, $urandom);
      end
      for (int p = 0; p < NRD; p++)
        if ($urandom_range(0, 3) != 0) set_rd(p, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)));
      issue_vld_i = 1'($urandom_range(0, 1)); issue_rd_wen_i = ($urandom_range(0, 3) != 0);
      issue_rd_idx_i = 5'($urandom_range(0, 7));
      settle();
      for (int p = 0; p < NRD; p++) if (!exp_pst[p]) begin
        chk++; if (rd_data_o[p] !== exp_data[p]) begin fails++; $display("FAIL rand_data c%0d p%0d: got %h want %h", c, p, rd_data_o[p], exp_data[p]); end
      end
      chk++; if (stall_o !== exp_stall) begin fails++; $display("FAIL rand_stall c%0d: got %b want %b", c, stall_o, exp_stall); end
      tick();
    end
    chk++; if (stall_cnt_o !== m_cnt) begin fails++; $display("FAIL rand_cnt: got %h want %h", stall_cnt_o, m_cnt); end
    clear_in();
  endtask

  task automatic test_async_reset();
    set_issue(5'd3); tick();
    set_issue(5'd3); set_rd(0, 5'd3, SW); settle();
    chk++; if (stall_o !== 1'b1) begin fails++; $display("FAIL pre_reset_stall: got %b want 1", stall_o); end
    tick(); set_issue(5'd3); set_rd(0, 5'd3, SW);
    chk++; if (stall_cnt_o !== m_cnt || m_cnt == 32'd0) begin fails++; $display("FAIL pre_reset_cnt: got %h want %h", stall_cnt_o, m_cnt); end
    #2 rst_n_i = 1'b0; model_reset();
    #1;
    chk++; if (stall_cnt_o !== 32'h0) begin fails++; $display("FAIL async_cnt: got %h want 0", stall_cnt_o); end
    clear_in(); set_rd(0, 5'd5, SW); set_rd(1, 5'd9, SW); settle();
    chk++; if (rd_data_o[0] !== 32'h0 || rd_data_o[1] !== 32'h0 || stall_o !== 1'b0) begin
      fails++; $display("FAIL async_regs: got %h/%h stall %b want 0/0 stall 0", rd_data_o[0], rd_data_o[1], stall_o);
    end
    set_rd(0, 5'd3, SW); settle();
    chk++; if (stall_o !== 1'b0) begin fails++; $display("FAIL async_pend: got %b want 0", stall_o); end
    rst_n_i = 1'b1;
    clear_in();
    tick();
  endtask

  initial begin
    clear_in();
    model_reset();
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    test_reset();
    test_size_ext();
    test_fwd();
    test_pending();
    test_saturation();
    test_x0();
    test_flush();
    test_random();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
    $finish;
  end

endmodule

// File: doc/k423_id_regfile_sb.md
# k423_id_regfile_sb

Parametrised successor of the ID-stage register file: an N-read / M-write integer register file with a generic forwarding network and a per-register pending-write scoreboard. It produces read operands in the ID stage and raises a stall when an operand's producer is in flight but its data is not yet forwardable (e.g. a load in EX). It sits in the ID stage, between decode and the ID/EX pipeline register.

## Interface
Parameters:
- NUM_RD, 2, read ports.
- NUM_WR, 1, write ports; higher index wins on same-register conflict.
- NUM_FWD, 3, forward sources; index 0 is youngest (EX), highest priority.
- XLEN, `CORE_XLEN, data width.
- PEND_W, 2, pending-counter width per register.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset. One clock; reset is asynchronous and active-low.
- flush_i  in  1  full pipeline flush; clears all pending counters.
- fwd_vld_i  in  NUM_FWD  source holds a register-writing instruction.
- fwd_data_vld_i  in  NUM_FWD  source data is final.
- fwd_idx_i  in  NUM_FWD×`INST_RSDIDX_W  destination index per source.
- fwd_data_i  in  NUM_FWD×XLEN  data per source.
- wr_vld_i  in  NUM_WR  write enable.
- wr_idx_i  in  NUM_WR×`INST_RSDIDX_W  write index.
- wr_data_i  in  NUM_WR×XLEN  write data.
- rd_vld_i  in  NUM_RD  operand used.
- rd_idx_i  in  NUM_RD×`INST_RSDIDX_W  operand index.
- rd_size_i  in  NUM_RD×`RSD_SIZE_W  BYTE/HALF/WORD; sign-extends the selected data.
- rd_data_o  out  NUM_RD×XLEN  operand data.
- issue_vld_i  in  1  decoded instruction wants to leave ID.
- issue_rd_wen_i  in  1  instruction writes rd.
- issue_rd_idx_i  in  `INST_RSDIDX_W  its rd.
- stall_o  out  1  hold ID; issue does not fire.
- stall_cnt_o  out  32  saturating count of cycles with issue_vld_i & stall_o.

## Operation
- Issue fires when issue_vld_i & !stall_o. If it fires with issue_rd_wen_i and rd≠0, pend[rd] increments. A retire (wr_vld_i with idx≠0) decrements pend[idx].
- Issue and retire on the same register in the same cycle leave pend unchanged. Duplicate retires to one register in one cycle decrement it once.
- flush_i sets every pend to 0; a simultaneous issue and retire are ignored for the scoreboard. The write itself still occurs. The pipeline asserts flush_i only when no older write remains in flight beyond the current cycle's write.
- Write: at the clock edge, regfile[wr_idx] ← wr_data for each valid port with idx≠0; the highest port index wins. x0 always reads 0.
- Read, per port p:
  - If rd_vld_i=0 or idx=0, output 0, no stall.
  - Otherwise take the lowest-index fwd source s with fwd_vld_i[s] and fwd_idx_i[s]==idx. If it exists and fwd_data_vld_i[s], select fwd_data_i[s]; if it exists without data, request a stall.
  - Else, if a write port targets idx this cycle, select its data (write-first bypass; highest port wins).
  - Else, if pend[idx]≠0, request a stall (producer is invisible to forwarding).
  - Else, select regfile[idx].
  - Apply rd_size_i extension: BYTE sign-extends [7:0], HALF sign-extends [15:0], WORD passes through.
- stall_o is the OR of all port stall requests OR (issue_rd_wen_i & rd≠0 & pend[rd] saturated & no retire of rd this cycle).
- A port with rd_vld_i=0 never stalls.

## Timing
- Reads and stall_o are combinational, zero latency.
- A write is visible from regfile the next cycle; the same cycle is covered by the bypass.
- A pend update is visible the next cycle.
- Reset: all registers 0, all pend 0, stall_cnt_o 0. rd_data_o and stall_o are combinational; with all valids low they are 0.
- Reset asserted mid-operation clears state immediately (asynchronous).
- stall_cnt_o holds at 0xFFFF_FFFF.

## Structure
- The RSD_SIZE encodings, `INST_RSDIDX_W and `CORE_XLEN stay in k423_defines.svh. Add `RF_NREG (32).
- The sub-module k423_id_scoreboard contains the pend counters, issue/retire/flush logic, a per-index busy vector and the saturation flag.
- The read muxing and the regfile array stay in the top module, generated per read port.

## Test plan
- Write x5=0x80 via wr port, then read x5 with BYTE the next cycle → 0xFFFF_FF80; with WORD → 0x0000_0080.
- fwd0 (idx 7, data_vld=0) and fwd1 (idx 7, data 0x11, valid); read x7 → stall_o=1. Same with fwd0 data_vld=1, data 0x22 → 0x22, stall_o=0.
- Issue rd=3, then drop all fwd valids and read x3 → stall_o=1. Retire x3=0x9 → same-cycle read returns 0x9 via bypass; next cycle pend=0.
- Issue rd=4 three times without retire (PEND_W=2) → the fourth attempt sees stall_o=1 and pend stays 3. A retire in the same cycle as the fourth issue → it fires, pend stays 3.
- Write x0=0xFFFF plus issue rd=0 → x0 reads 0 and pend never changes.
- flush_i with pend[9]=2 → next cycle reading x9 gives the regfile value with no stall. Assert rst_n_i low mid-stall → stall_cnt_o=0 and all registers read 0.
